// File: rtl/pkt_drop_filter_if.sv
// AXI-Stream style bundle used for both the ingress and egress ports of the
// packet drop filter.
interface pkt_drop_filter_if #(
    parameter int DATA_WIDTH  = 512,
    parameter int TUSER_WIDTH = 128
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic [TUSER_WIDTH-1:0]  tuser;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (output tdata, output tkeep, output tuser, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tuser, input tvalid, input tlast, output tready);
endinterface

// File: rtl/pkt_drop_filter.sv
// Per-packet pass/drop filter: the first beat's key is matched against a small
// priority rule table and the whole packet is then forwarded or discarded.
module pkt_drop_filter #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int KEY_LSB              = 368,
    parameter int KEY_WIDTH            = 16,
    parameter int NUM_RULES            = 4,
    parameter int DEFAULT_DROP         = 1,
    parameter int CNT_WIDTH            = 32,
    localparam int IDX_W               = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
    input  logic                  clk,
    input  logic                  aresetn,
    pkt_drop_filter_if.slave      s_axis,
    pkt_drop_filter_if.master     m_axis,
    input  logic                  cfg_wr_en,
    input  logic [IDX_W-1:0]      cfg_wr_idx,
    input  logic [KEY_WIDTH-1:0]  cfg_wr_key,
    input  logic                  cfg_wr_enable,
    input  logic                  cfg_wr_drop,
    output logic [CNT_WIDTH-1:0]  pass_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                            state_r;
    state_t                            next_state_s;
    logic                              rule_en_r   [NUM_RULES];
    logic [KEY_WIDTH-1:0]              rule_key_r  [NUM_RULES];
    logic                              rule_drop_r [NUM_RULES];
    logic                              match_drop_s;
    logic                              s_ready_s;
    logic                              accept_s;
    logic                              load_s;
    logic                              count_pass_s;
    logic                              count_drop_s;
    logic                              m_valid_r;
    logic                              m_last_r;
    logic [C_S_AXIS_DATA_WIDTH-1:0]    m_data_r;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_keep_r;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_user_r;
    logic [CNT_WIDTH-1:0]              pass_cnt_r;
    logic [CNT_WIDTH-1:0]              drop_cnt_r;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_WIDTH'(1);
        end
    endfunction

    // Rule table; indices with no matching slot fall through and are ignored.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_RULES; i++) begin
                rule_en_r[i]   <= 1'b0;
                rule_key_r[i]  <= '0;
                rule_drop_r[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_RULES; i++) begin
                if (cfg_wr_en && (cfg_wr_idx == IDX_W'(i))) begin
                    rule_en_r[i]   <= cfg_wr_enable;
                    rule_key_r[i]  <= cfg_wr_key;
                    rule_drop_r[i] <= cfg_wr_drop;
                end
            end
        end
    end

    // Priority lookup: scan downward so the lowest matching index wins.
    always_comb begin
        match_drop_s = (DEFAULT_DROP != 0);
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (rule_en_r[i] && (rule_key_r[i] == s_axis.tdata[KEY_LSB +: KEY_WIDTH])) begin
                match_drop_s = rule_drop_r[i];
            end else begin
                match_drop_s = match_drop_s;
            end
        end
    end

    // Ingress ready; dropped beats are sunk regardless of egress backpressure.
    always_comb begin
        s_ready_s = 1'b0;
        if (!aresetn) begin
            s_ready_s = 1'b0;
        end else if (state_r == ST_DROP) begin
            s_ready_s = 1'b1;
        end else begin
            s_ready_s = !m_valid_r || m_axis.tready;
        end
    end

    assign accept_s      = s_axis.tvalid && s_ready_s;
    assign s_axis.tready = s_ready_s;

    // Next-state and per-beat action decode.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        count_pass_s = 1'b0;
        count_drop_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && match_drop_s) begin
                    count_drop_s = 1'b1;
                    next_state_s = s_axis.tlast ? ST_IDLE : ST_DROP;
                end else if (accept_s) begin
                    count_pass_s = 1'b1;
                    load_s       = 1'b1;
                    next_state_s = s_axis.tlast ? ST_IDLE : ST_PASS;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_PASS: begin
                if (accept_s) begin
                    load_s       = 1'b1;
                    next_state_s = s_axis.tlast ? ST_IDLE : ST_PASS;
                end else begin
                    next_state_s = ST_PASS;
                end
            end
            ST_DROP: begin
                if (accept_s) begin
                    next_state_s = s_axis.tlast ? ST_IDLE : ST_DROP;
                end else begin
                    next_state_s = ST_DROP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register and saturating packet counters.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_r    <= ST_IDLE;
            pass_cnt_r <= '0;
            drop_cnt_r <= '0;
        end else begin
            state_r <= next_state_s;
            if (count_pass_s) begin
                pass_cnt_r <= sat_inc(pass_cnt_r);
            end
            if (count_drop_s) begin
                drop_cnt_r <= sat_inc(drop_cnt_r);
            end
        end
    end

    // Egress register: loads only when empty or draining, so a stalled beat holds.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            m_data_r  <= '0;
            m_keep_r  <= '0;
            m_user_r  <= '0;
        end else if (load_s) begin
            m_valid_r <= 1'b1;
            m_last_r  <= s_axis.tlast;
            m_data_r  <= s_axis.tdata;
            m_keep_r  <= s_axis.tkeep;
            m_user_r  <= s_axis.tuser;
        end else if (m_axis.tready) begin
            m_valid_r <= 1'b0;
        end
    end

    assign m_axis.tvalid = m_valid_r;
    assign m_axis.tlast  = m_last_r;
    assign m_axis.tdata  = m_data_r;
    assign m_axis.tkeep  = m_keep_r;
    assign m_axis.tuser  = m_user_r;
    assign pass_cnt      = pass_cnt_r;
    assign drop_cnt      = drop_cnt_r;

endmodule

// File: tb/tb_pkt_drop_filter.sv
// Directed bench for pkt_drop_filter: expected egress beats go into a queue
// that an independent monitor drains and compares.
module tb_pkt_drop_filter;

    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        logic [127:0] user;
        logic         last;
    } beat_t;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        cfg_wr_en;
    logic [1:0]  cfg_wr_idx;
    logic [15:0] cfg_wr_key;
    logic        cfg_wr_enable;
    logic        cfg_wr_drop;
    logic [31:0] pass_cnt;
    logic [31:0] drop_cnt;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    beat_t exp_q[$];

    pkt_drop_filter_if #(.DATA_WIDTH(512), .TUSER_WIDTH(128)) s_if ();
    pkt_drop_filter_if #(.DATA_WIDTH(512), .TUSER_WIDTH(128)) m_if ();

    pkt_drop_filter dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .s_axis        (s_if.slave),
        .m_axis        (m_if.master),
        .cfg_wr_en     (cfg_wr_en),
        .cfg_wr_idx    (cfg_wr_idx),
        .cfg_wr_key    (cfg_wr_key),
        .cfg_wr_enable (cfg_wr_enable),
        .cfg_wr_drop   (cfg_wr_drop),
        .pass_cnt      (pass_cnt),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every valid egress cycle must match the queue head; pop on handshake.
    always @(negedge clk) begin
        if (aresetn && m_if.tvalid) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL beat_unexpected: got data %h with nothing expected", m_if.tdata[63:0]);
            end else if (m_if.tdata !== exp_q[0].data || m_if.tkeep !== exp_q[0].keep ||
                         m_if.tuser !== exp_q[0].user || m_if.tlast !== exp_q[0].last) begin
                mismatched++;
                $display("FAIL beat: got data %h last %b expected data %h last %b",
                         m_if.tdata, m_if.tlast, exp_q[0].data, exp_q[0].last);
                if (m_if.tready) void'(exp_q.pop_front());
            end else if (m_if.tready) begin
                void'(exp_q.pop_front());
            end
        end
    end

    function automatic logic [511:0] mk_data(input logic [15:0] key);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
        d[368 +: 16] = key;
        return d;
    endfunction

    function automatic beat_t mk_beat(input logic [15:0] key, input logic last);
        beat_t b;
        b.data = mk_data(key);
        b.keep = {$urandom(), $urandom()};
        b.user = {$urandom(), $urandom(), $urandom(), $urandom()};
        b.last = last;
        return b;
    endfunction

    task automatic drive(input beat_t b);
        s_if.tdata  = b.data;
        s_if.tkeep  = b.keep;
        s_if.tuser  = b.user;
        s_if.tlast  = b.last;
        s_if.tvalid = 1'b1;
    endtask

    // Returns at posedge+1 after the beat currently driven was accepted.
    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (!s_if.tready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) check("accept_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input beat_t b, input bit fwd);
        if (fwd) exp_q.push_back(b);
        drive(b);
        wait_accept();
    endtask

    task automatic send_pkt(input logic [15:0] key, input int nbeats, input bit fwd);
        for (int i = 0; i < nbeats; i++) send_beat(mk_beat(key, (i == nbeats - 1)), fwd);
        s_if.tvalid = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [15:0] key, input logic en, input logic drp);
        cfg_wr_en = 1'b1; cfg_wr_idx = idx; cfg_wr_key = key; cfg_wr_enable = en; cfg_wr_drop = drp;
        @(posedge clk);
        #1;
        cfg_wr_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            n++;
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        #1;
        check("queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        beat_t b;
        aresetn = 1'b0;
        s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = '0;
        m_if.tready = 1'b1;
        cfg_wr_en = 1'b0; cfg_wr_idx = 2'd0; cfg_wr_key = 16'd0; cfg_wr_enable = 1'b0; cfg_wr_drop = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_m_tdata", 64'(|m_if.tdata), 64'd0);
        check("rst_s_tready", 64'(s_if.tready), 64'd0);
        check("rst_pass_cnt", 64'(pass_cnt), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        @(posedge clk); #1;
        aresetn = 1'b1;
        @(posedge clk); #1;

        // Empty table, default drop
        send_pkt(16'h0800, 2, 1'b0);
        drain();
        check("drop_default_cnt", 64'(drop_cnt), 64'd1);
        check("drop_default_pass", 64'(pass_cnt), 64'd0);

        // Single-beat pass, latency one cycle
        cfg_write(2'd0, 16'h0800, 1'b1, 1'b0);
        send_beat(mk_beat(16'h0800, 1'b1), 1'b1);
        check("lat1_tvalid", 64'(m_if.tvalid), 64'd1);
        check("lat1_tlast", 64'(m_if.tlast), 64'd1);
        s_if.tvalid = 1'b0;
        drain();
        check("single_pass_cnt", 64'(pass_cnt), 64'd1);

        // Lowest index wins, full rate
        cfg_write(2'd1, 16'h0800, 1'b1, 1'b1);
        c0 = cyc;
        send_pkt(16'h0800, 3, 1'b1);
        check("throughput_cycles", 64'(cyc - c0), 64'd3);
        drain();
        check("prio_pass_cnt", 64'(pass_cnt), 64'd2);

        // Disabled rule must not match
        cfg_write(2'd2, 16'h86DD, 1'b0, 1'b0);
        send_pkt(16'h86DD, 1, 1'b0);
        drain();
        check("disabled_drop_cnt", 64'(drop_cnt), 64'd2);

        // Backpressure mid-packet
        send_beat(mk_beat(16'h0800, 1'b0), 1'b1);
        m_if.tready = 1'b0;
        b = mk_beat(16'h0800, 1'b0);
        exp_q.push_back(b);
        drive(b);
        repeat (5) begin
            @(negedge clk);
            check("stall_s_tready", 64'(s_if.tready), 64'd0);
        end
        @(posedge clk); #1;
        m_if.tready = 1'b1;
        wait_accept();
        send_beat(mk_beat(16'h0800, 1'b1), 1'b1);
        s_if.tvalid = 1'b0;
        drain();
        check("stall_pass_cnt", 64'(pass_cnt), 64'd3);

        // Rule write coincident with first beat uses the old table
        b = mk_beat(16'h0800, 1'b1);
        exp_q.push_back(b);
        drive(b);
        cfg_wr_en = 1'b1; cfg_wr_idx = 2'd0; cfg_wr_key = 16'h0800; cfg_wr_enable = 1'b1; cfg_wr_drop = 1'b1;
        @(negedge clk);
        check("coincident_s_tready", 64'(s_if.tready), 64'd1);
        @(posedge clk); #1;
        cfg_wr_en = 1'b0;
        s_if.tvalid = 1'b0;
        drain();
        check("coincident_pass_cnt", 64'(pass_cnt), 64'd4);
        send_pkt(16'h0800, 1, 1'b0);
        drain();
        check("after_write_drop_cnt", 64'(drop_cnt), 64'd3);

        // Reset during a dropped packet
        send_beat(mk_beat(16'h1234, 1'b0), 1'b0);
        send_beat(mk_beat(16'h1234, 1'b0), 1'b0);
        s_if.tvalid = 1'b0;
        check("pre_reset_drop_cnt", 64'(drop_cnt), 64'd4);
        aresetn = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
            check("mid_rst_s_tready", 64'(s_if.tready), 64'd0);
            check("mid_rst_cnts", {pass_cnt, drop_cnt}, 64'd0);
        end
        @(posedge clk); #1;
        aresetn = 1'b1;
        cfg_write(2'd0, 16'h1234, 1'b1, 1'b0);
        send_beat(mk_beat(16'h1234, 1'b0), 1'b1);
        send_beat(mk_beat(16'h1234, 1'b1), 1'b1);
        s_if.tvalid = 1'b0;
        drain();
        check("post_rst_pass_cnt", 64'(pass_cnt), 64'd1);
        check("post_rst_drop_cnt", 64'(drop_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
